// File: rtl/cpu_pkg.sv
// Shared core types and defaults for the fetch front end: address width, reset vector, next-PC select encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

  // Encoding matches the PCSrc wire coming out of branch resolution.
  typedef enum logic {
    PC_SEL_SEQ    = 1'b0,
    PC_SEL_BRANCH = 1'b1
  } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select between sequential and branch target; no state, zero latency.
// With PC_ALIGN_CHECK_EN defined, the low two bits are cleared and a misalignment flag is produced.
module pc_next_mux #(
  parameter int XLEN = 32
) (
  input  logic            i_sel,
  input  logic [XLEN-1:0] i_pc_seq,
  input  logic [XLEN-1:0] i_pc_branch,
`ifdef PC_ALIGN_CHECK_EN
  output logic            o_misaligned,
`endif
  output logic [XLEN-1:0] o_pc_next
);
  import cpu_pkg::*;

  pc_sel_e         w_sel;
  logic [XLEN-1:0] w_pc_sel;

  assign w_sel = pc_sel_e'(i_sel);

  always_comb begin
    w_pc_sel = i_pc_seq;
    case (w_sel)
      PC_SEL_BRANCH: w_pc_sel = i_pc_branch;
      default:       w_pc_sel = i_pc_seq;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Instructions are word aligned; a target with low bits set is flagged and rounded down.
  assign o_misaligned = |w_pc_sel[1:0];
  assign o_pc_next    = {w_pc_sel[XLEN-1:2], 2'b00};
`else
  assign o_pc_next    = w_pc_sel;
`endif

endmodule

// File: rtl/program_counter.sv
// Architectural PC register at the head of fetch: loads PC_in or PCimm_in every edge, one-cycle latency.
// Synchronous active-high reset loads RESET_VECTOR; PC_ALIGN_CHECK_EN adds alignment masking and pc_misaligned.
module program_counter #(
  parameter int              XLEN         = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(cpu_pkg::RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCimm_in,
  input  logic [XLEN-1:0] PC_in,
  output logic [XLEN-1:0] PC_out
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            pc_misaligned
`endif
);
  import cpu_pkg::*;

  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misaligned;
`endif

  pc_next_mux #(
    .XLEN (XLEN)
  ) u_pc_next_mux (
    .i_sel       (PCSrc),
    .i_pc_seq    (PC_in),
    .i_pc_branch (PCimm_in),
`ifdef PC_ALIGN_CHECK_EN
    .o_misaligned(w_misaligned),
`endif
    .o_pc_next   (w_pc_next)
  );

  // No stall input: the register reloads on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign PC_out = r_pc;

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misaligned;
    end
  end

  assign pc_misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Randomized and directed bench for program_counter against a behavioural next-PC model.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCimm_in;
  logic [31:0] PC_in;
  logic [31:0] PC_out;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
  logic        m_mis;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  program_counter dut (
    .clk      (clk),
    .reset    (reset),
    .PCSrc    (PCSrc),
    .PCimm_in (PCimm_in),
    .PC_in    (PC_in),
`ifdef PC_ALIGN_CHECK_EN
    .pc_misaligned(pc_misaligned),
`endif
    .PC_out   (PC_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; before the edge the PC must still show the previous value,
  // after the edge it must show what the rules predict.
  task automatic step(input string tag, input bit rst, input bit src,
                      input logic [31:0] imm, input logic [31:0] seq);
    logic [31:0] sel;
    reset    = rst;
    PCSrc    = src;
    PCimm_in = imm;
    PC_in    = seq;
    #2;
    if (m_valid) chk({tag, "/hold"}, PC_out, m_pc);
    sel = src ? imm : seq;
    if (rst) begin
      m_pc = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
      m_mis = 1'b0;
`endif
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      m_pc  = sel & ~32'd3;
      m_mis = (sel % 4) != 0;
`else
      m_pc  = sel;
`endif
    end
    m_valid = 1'b1;
    @(posedge clk);
    #1;
    chk(tag, PC_out, m_pc);
`ifdef PC_ALIGN_CHECK_EN
    chk({tag, "/mis"}, {31'b0, pc_misaligned}, {31'b0, m_mis});
`endif
  endtask

  initial begin
    bit          r_rst;
    bit          r_src;
    logic [31:0] r_imm;
    logic [31:0] r_seq;

    reset    = 1'b1;
    PCSrc    = 1'b0;
    PCimm_in = 32'd44;
    PC_in    = 32'd0;
    @(negedge clk);

    // Reset hold over two edges.
    step("rst0", 1'b1, 1'b0, 32'd44, 32'd0);
    step("rst1", 1'b1, 1'b0, 32'd44, 32'd0);

    // Sequential fetch.
    step("seq8",  1'b0, 1'b0, 32'd0, 32'd8);
    step("seq12", 1'b0, 1'b0, 32'd0, 32'd12);
    step("seq16", 1'b0, 1'b0, 32'd0, 32'd16);

    // Single-cycle branch pulse.
    step("br72",  1'b0, 1'b1, 32'd72, 32'd24);
    step("seq28", 1'b0, 1'b0, 32'd72, 32'd28);

    // Reset beats a simultaneous branch; PC holds 100 until that edge.
    step("seq100",  1'b0, 1'b0, 32'd0,  32'd100);
    step("rstprio", 1'b1, 1'b1, 32'd56, 32'd0);

    // Full-width values pass unmodified.
    step("brmax",  1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0);
    step("seqmsb", 1'b0, 1'b0, 32'd0, 32'h8000_0000);

    // Misaligned target then aligned sequential.
    step("br42",  1'b0, 1'b1, 32'd42, 32'd0);
    step("seq44", 1'b0, 1'b0, 32'd0,  32'd44);

    // Reset deassert loads the selected input on the very next edge.
    step("rstA",  1'b1, 1'b0, 32'd0, 32'd0);
    step("first", 1'b0, 1'b1, 32'h0000_1230, 32'd4);

    for (int i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(15) == 0);
      r_src = 1'($urandom_range(1));
      r_imm = $urandom;
      r_seq = ($urandom_range(1) == 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step("rand", r_rst, r_src, r_imm, r_seq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
